// File: rtl/modn_counter_updown.sv
// rtl/modn_counter_updown.sv - multi-digit modulo-N up/down counter with load, enable and wrap pulse
// Optional SATURATE_EN: counting holds at the boundary instead of wrapping.
module modn_counter_updown #(
   parameter int MODULUS = 10,
   parameter int DIGITS = 2,
   localparam int DW = $clog2(MODULUS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 up_dn,
   input  logic                 load,
   input  logic [DIGITS*DW-1:0] load_val,
   output logic [DIGITS*DW-1:0] out,
   output logic                 tc,
   output logic                 wrap
);

   localparam logic [DW-1:0] MAX_D = DW'(MODULUS - 1);
   localparam logic [DW:0]   MOD_W = (DW + 1)'(MODULUS);

   logic [DIGITS*DW-1:0] out_q, out_d;
   logic                 wrap_q, wrap_d;
   logic [DIGITS*DW-1:0] stepped;
   logic [DIGITS*DW-1:0] clamped;
   logic                 all_max, all_zero, at_bound;
   logic                 carry;
   logic [DW-1:0]        dig;

   // Carry/borrow ripples combinationally through every digit in one edge.
   always_comb begin
      stepped  = out_q;
      clamped  = load_val;
      all_max  = 1'b1;
      all_zero = 1'b1;
      carry    = 1'b1;
      dig      = '0;
      for (int k = 0; k < DIGITS; k++) begin
         dig = out_q[k*DW +: DW];
         if (dig != MAX_D) all_max = 1'b0;
         if (dig != '0) all_zero = 1'b0;
         if (carry) begin
            if (up_dn) stepped[k*DW +: DW] = (dig == MAX_D) ? '0 : dig + DW'(1);
            else       stepped[k*DW +: DW] = (dig == '0) ? MAX_D : dig - DW'(1);
         end
         carry = carry & (up_dn ? (dig == MAX_D) : (dig == '0));
         if ({1'b0, load_val[k*DW +: DW]} >= MOD_W) clamped[k*DW +: DW] = MAX_D;
      end
   end

   assign at_bound = up_dn ? all_max : all_zero;

   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      if (reset) begin
         out_d = '0;
      end else if (load) begin
         out_d = clamped;
      end else if (en) begin
`ifdef SATURATE_EN
         if (!at_bound) out_d = stepped;
`else
         out_d  = stepped;
         wrap_d = at_bound;
`endif
      end
   end

   always_ff @(negedge clk) begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
   end

   assign out  = out_q;
   assign wrap = wrap_q;
   assign tc   = en & at_bound;

endmodule

// File: tb/tb_modn_counter_updown.sv
// tb/tb_modn_counter_updown.sv - scoreboard bench for modn_counter_updown against an integer-value model
module tb_modn_counter_updown;
   localparam int M  = 10;
   localparam int D  = 2;
   localparam int DW = $clog2(M);
   localparam int W  = D * DW;

   logic clk = 1'b0;
   logic reset = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] out;
   logic tc, wrap;

   modn_counter_updown #(.MODULUS(M), .DIGITS(D)) dut (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .out(out), .tc(tc), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct { logic [W-1:0] o; logic w; } exp_t;
   exp_t exp_q[$];
   logic tc_q[$];

   int n_cmp = 0, n_fail = 0;
   int model_v = 0;
   bit model_known = 0;
   bit done = 0;
   int total_n;

   function automatic int pow_m(input int e);
      int p = 1;
      for (int i = 0; i < e; i++) p = p * M;
      return p;
   endfunction

   function automatic logic [W-1:0] pack(input int v);
      logic [W-1:0] p = '0;
      int t = v;
      for (int k = 0; k < D; k++) begin
         p[k*DW +: DW] = DW'(t % M);
         t = t / M;
      end
      return p;
   endfunction

   function automatic int unpack_clamped(input logic [W-1:0] lv);
      int v = 0;
      int dgt;
      for (int k = 0; k < D; k++) begin
         dgt = int'(lv[k*DW +: DW]);
         if (dgt >= M) dgt = M - 1;
         v = v + dgt * pow_m(k);
      end
      return v;
   endfunction

   // Drive one cycle of inputs and record what the counter must show.
   task automatic step(input bit r, input bit l, input logic [W-1:0] lv, input bit e, input bit u);
      exp_t x;
      bit w;
      @(posedge clk);
      #1;
      reset = r; load = l; load_val = lv; en = e; up_dn = u;
      if (model_known) tc_q.push_back(e && (u ? (model_v == total_n - 1) : (model_v == 0)));
      w = 0;
      if (r) begin
         model_v = 0; model_known = 1;
      end else if (l) begin
         model_v = unpack_clamped(lv); model_known = 1;
      end else if (e && model_known) begin
`ifdef SATURATE_EN
         if (u && model_v != total_n - 1) model_v = model_v + 1;
         else if (!u && model_v != 0) model_v = model_v - 1;
`else
         if (u) begin
            w = (model_v == total_n - 1);
            model_v = (model_v + 1) % total_n;
         end else begin
            w = (model_v == 0);
            model_v = (model_v + total_n - 1) % total_n;
         end
`endif
      end
      if (model_known) begin
         x.o = pack(model_v);
         x.w = w;
         exp_q.push_back(x);
      end
   endtask

   initial begin : monitor
      exp_t x;
      logic t;
      forever begin
         @(posedge clk);
         #3;
         if (tc_q.size() > 0) begin
            t = tc_q.pop_front();
            n_cmp++;
            if (tc !== t) begin
               n_fail++;
               $display("FAIL tc: got %b expected %b at %0t", tc, t, $time);
            end
         end
         @(negedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_cmp++;
            if (out !== x.o || wrap !== x.w) begin
               n_fail++;
               $display("FAIL out/wrap: got %h/%b expected %h/%b at %0t", out, wrap, x.o, x.w, $time);
            end
         end
      end
   end

   initial begin : driver
      logic [W-1:0] lv;
      total_n = pow_m(D);
      step(1, 0, '0, 0, 0);
      step(1, 0, '0, 1, 0);
      repeat (3) step(0, 0, '0, 1, 0);
      step(0, 1, W'('h09), 0, 0);
      step(0, 0, '0, 1, 1);
      step(0, 1, W'('h90), 0, 1);
      step(0, 0, '0, 1, 0);
      step(0, 1, W'('h99), 0, 0);
      step(0, 0, '0, 1, 1);
      step(0, 0, '0, 0, 1);
      step(0, 1, W'('hC5), 0, 0);
      step(0, 1, W'('h42), 1, 1);
      step(0, 1, W'('hFF), 1, 0);
      step(0, 1, W'('h01), 0, 0);
      repeat (3) step(0, 0, '0, 1, 0);
      step(1, 0, '0, 0, 1);
      repeat (57) step(0, 0, '0, 1, 1);
      step(1, 0, '0, 1, 1);
      for (int i = 0; i < 3000; i++) begin
         lv = W'($urandom);
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), lv,
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
      end
      step(0, 0, '0, 0, 0);
      repeat (3) @(posedge clk);
      n_cmp++;
      if (exp_q.size() != 0 || tc_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q.size(), tc_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
